fetch_stage: RTL

Parametrised instruction-fetch front end for the RISC processor; replaces the bare PC / PC+1 adder / instruction-memory path with a sequenced fetch stage. It issues word-addressed requests to a synchronous instruction memory, buffers returned instructions with their PCs in a small queue, and presents them to decode through a valid/ready handshake. It supports branch/jump redirect with flush and stops fetching on a halt opcode.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] DEF_HALT_OP = 4'hF;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Default queue entry; fetch_stage builds a width-matched copy for its own parameters.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetched {pc, inst} entries with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter type entry_t = fetch_entry_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = CNT_W - 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush overrides both push and pop; pop of an empty queue is ignored.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - sequenced instruction fetch with redirect, halt and decode handshake
// Optional FETCH_PERF_EN adds the Perf_fetched / Perf_stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_W   = 32,
  parameter int                    INST_W   = 32,
  parameter int                    DEPTH    = 4,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [OPCODE_W-1:0]   HALT_OP  = DEF_HALT_OP
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Redirect,
  input  logic [ADDR_W-1:0]   Redirect_pc,
  output logic                Imem_req,
  output logic [ADDR_W-1:0]   Imem_addr,
  input  logic [INST_W-1:0]   Imem_data,
  output logic                Inst_valid,
  input  logic                Inst_ready,
  output logic [INST_W-1:0]   Inst,
  output logic [ADDR_W-1:0]   Inst_pc,
  output logic [OPCODE_W-1:0] Opcode
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         Perf_fetched,
  output logic [31:0]         Perf_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      state;
  fetch_state_e      state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue;
  logic              cap_ok;
  logic              halt_push;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ_total;
  entry_t            head;
  entry_t            push_entry;

  // Capacity counts the in-flight slot so a returning word always has room.
  assign occ_total  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign cap_ok     = occ_total < DEPTH_C;
  assign halt_push  = inflight && (Imem_data[INST_W-1 -: OPCODE_W] == HALT_OP);
  assign push_entry = '{pc: inflight_pc, inst: Imem_data};

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    if (Redirect) begin
      state_nx = RUN;
    end else begin
      if (halt_push) begin
        state_nx = HALTED;
      end
      issue = !Rst && (state == RUN) && !halt_push && cap_ok;
    end
  end

  assign Imem_req  = issue;
  assign Imem_addr = fetch_pc;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (Redirect) begin
        fetch_pc <= Redirect_pc;
      end else if (issue) begin
        fetch_pc    <= fetch_pc + ADDR_W'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .entry_t (entry_t)
  ) u_queue (
    .clk        (Clk),
    .rst        (Rst),
    .flush      (Redirect),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (Inst_ready),
    .head       (head),
    .count      (count)
  );

  assign Inst_valid = (count != '0);
  assign Inst       = Inst_valid ? head.inst : '0;
  assign Inst_pc    = Inst_valid ? head.pc : '0;
  assign Opcode     = Inst[INST_W-1 -: OPCODE_W];

`ifdef FETCH_PERF_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Perf_fetched <= '0;
      Perf_stall   <= '0;
    end else begin
      if (Inst_valid && Inst_ready && !Redirect) begin
        Perf_fetched <= Perf_fetched + 32'd1;
      end
      if ((state == RUN) && !Redirect && !cap_ok) begin
        Perf_stall <= Perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
